// File: rtl/mux_bin_arb_rr.sv
// Round-robin arbiter with packet lock. One binary-select mux is shared among
// WIDTH valid/ready requesters and feeds a 1-deep registered output stage.
module mux_bin_arb_rr #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_req_vld,
  input  logic [WIDTH-1:0]           i_req_lst,
  input  DAT_T [WIDTH-1:0]           i_req_dat,
  output logic [WIDTH-1:0]           o_req_rdy,
  output logic                       o_out_vld,
  output logic                       o_out_lst,
  output DAT_T                       o_out_dat,
  output logic [$clog2(WIDTH)-1:0]   o_out_bin,
  input  logic                       i_out_rdy
);

  localparam int WIDTH_LOG = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "mux_bin_arb_rr: WIDTH must be >= 2");
  end

  typedef enum logic {ARB, LOCK} state_t;

  state_t                 r_state;
  logic [WIDTH_LOG-1:0]   r_ptr;
  logic                   r_out_vld;
  logic                   r_out_lst;
  DAT_T                   r_out_dat;
  logic [WIDTH_LOG-1:0]   r_out_bin;

  logic [WIDTH_LOG-1:0]   w_gnt;
  logic                   w_stg_free;
  logic                   w_acc;

  // Scan from farthest to nearest so the nearest valid index after ptr wins;
  // the modulo keeps non-power-of-2 WIDTH from producing out-of-range indices.
  always_comb begin
    w_gnt = r_ptr;
    if (r_state == ARB) begin
      for (int k = WIDTH; k >= 1; k--) begin
        if (i_req_vld[(int'(r_ptr) + k) % WIDTH]) begin
          w_gnt = WIDTH_LOG'((int'(r_ptr) + k) % WIDTH);
        end
      end
    end
  end

  assign w_stg_free = !r_out_vld || i_out_rdy;
  assign w_acc      = i_rst_n && w_stg_free && i_req_vld[w_gnt];

  always_comb begin
    o_req_rdy = '0;
    if (w_acc) begin
      o_req_rdy[w_gnt] = 1'b1;
    end
  end

  // A packet's last beat returns to ARB; any other accepted beat locks onto gnt.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ARB;
      r_ptr     <= WIDTH_LOG'(WIDTH - 1);
      r_out_vld <= 1'b0;
      r_out_lst <= 1'b0;
      r_out_dat <= '0;
      r_out_bin <= '0;
    end else if (w_acc) begin
      r_out_vld <= 1'b1;
      r_out_lst <= i_req_lst[w_gnt];
      r_out_dat <= i_req_dat[w_gnt];
      r_out_bin <= w_gnt;
      r_ptr     <= w_gnt;
      r_state   <= i_req_lst[w_gnt] ? ARB : LOCK;
    end else if (i_out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  assign o_out_vld = r_out_vld;
  assign o_out_lst = r_out_lst;
  assign o_out_dat = r_out_dat;
  assign o_out_bin = r_out_bin;

endmodule

// File: tb/tb_mux_bin_arb_rr.sv
// Directed bench for mux_bin_arb_rr: a WIDTH=4 instance for arbitration, lock,
// backpressure and reset, plus a WIDTH=5 instance for index wrap-around.
module tb_mux_bin_arb_rr;

  logic clk = 1'b0;
  logic rstN;

  logic [3:0]      vld4, lst4, rdy4;
  logic [3:0][7:0] dat4;
  logic            outRdy4, ov4, ol4;
  logic [7:0]      od4;
  logic [1:0]      ob4;

  logic [4:0]      vld5, lst5, rdy5;
  logic [4:0][7:0] dat5;
  logic            outRdy5, ov5, ol5;
  logic [7:0]      od5;
  logic [2:0]      ob5;

  int checks = 0;
  int errors = 0;
  logic [3:0] prevPend4;

  mux_bin_arb_rr #(.DAT_T(logic [7:0]), .WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_vld(vld4), .i_req_lst(lst4), .i_req_dat(dat4), .o_req_rdy(rdy4),
    .o_out_vld(ov4), .o_out_lst(ol4), .o_out_dat(od4), .o_out_bin(ob4),
    .i_out_rdy(outRdy4)
  );

  mux_bin_arb_rr #(.DAT_T(logic [7:0]), .WIDTH(5)) dut5 (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_vld(vld5), .i_req_lst(lst5), .i_req_dat(dat5), .o_req_rdy(rdy5),
    .o_out_vld(ov5), .o_out_lst(ol5), .o_out_dat(od5), .o_out_bin(ob5),
    .i_out_rdy(outRdy5)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] vld, input logic [3:0] lst,
                               input logic outRdy);
    vld4    = vld;
    lst4    = lst;
    outRdy4 = outRdy;
    #1;
  endtask

  // A pending request must not be withdrawn before it has been accepted.
  always @(posedge clk) begin
    if (!rstN) begin
      prevPend4 <= '0;
    end else begin
      if (prevPend4 != 4'b0) begin
        checks++;
        assert ((prevPend4 & ~vld4) == 4'b0) else begin
          errors++;
          $error("[TB] FAIL reqRule observed=%0h expected=%0h", vld4 & prevPend4, prevPend4);
        end
      end
      prevPend4 <= vld4 & ~rdy4;
    end
  end

  initial begin
    rstN    = 1'b0;
    dat4[0] = 8'hA0; dat4[1] = 8'hA1; dat4[2] = 8'hA2; dat4[3] = 8'hA3;
    for (int i = 0; i < 5; i++) dat5[i] = 8'h50 + 8'(i);
    vld5 = '0; lst5 = '1; outRdy5 = 1'b1;
    applyStimulus(4'hF, 4'hF, 1'b1);

    // Reset with every requester valid
    repeat (2) tick();
    checkOutput("rst_vld4", ov4, 0);
    checkOutput("rst_bin4", ob4, 0);
    checkOutput("rst_rdy4", rdy4, 0);
    checkOutput("rst_lst4", ol4, 0);
    checkOutput("rst_dat4", od4, 0);
    checkOutput("rst_vld5", ov5, 0);
    checkOutput("rst_bin5", ob5, 0);

    // Round-robin over all four, then each drops after its final accept
    rstN = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("rr_rdy", rdy4, 32'(1 << (k % 4)));
      tick();
      checkOutput("rr_vld", ov4, 1);
      checkOutput("rr_bin", ob4, k % 4);
      checkOutput("rr_dat", od4, 8'hA0 + 8'(k % 4));
      if (k >= 4) vld4[k % 4] = 1'b0;
      #1;
    end

    // Three-beat packet from req 1 while req 2 waits
    dat4[1] = 8'hB1;
    applyStimulus(4'b0110, 4'b1101, 1'b1);
    checkOutput("lock_rdy0", rdy4, 4'b0010);
    tick();
    checkOutput("lock_bin0", ob4, 1);
    checkOutput("lock_dat0", od4, 8'hB1);
    checkOutput("lock_lst0", ol4, 0);
    dat4[1] = 8'hB2;
    #1;
    checkOutput("lock_rdy1", rdy4, 4'b0010);
    tick();
    checkOutput("lock_bin1", ob4, 1);
    checkOutput("lock_dat1", od4, 8'hB2);
    vld4[1] = 1'b0;
    #1;
    checkOutput("lock_wait_rdy", rdy4, 4'b0000);
    tick();
    checkOutput("lock_wait_vld", ov4, 0);
    checkOutput("lock_wait_bin", ob4, 1);
    vld4[1] = 1'b1; dat4[1] = 8'hB3; lst4[1] = 1'b1;
    #1;
    checkOutput("lock_rdy2", rdy4, 4'b0010);
    tick();
    checkOutput("lock_bin2", ob4, 1);
    checkOutput("lock_dat2", od4, 8'hB3);
    checkOutput("lock_lst2", ol4, 1);
    vld4[1] = 1'b0;
    #1;
    checkOutput("unlock_rdy", rdy4, 4'b0100);
    tick();
    checkOutput("unlock_bin", ob4, 2);
    checkOutput("unlock_dat", od4, 8'hA2);
    vld4[2] = 1'b0;

    // Backpressure holds the stage and blocks every requester
    dat4[3] = 8'hC3;
    applyStimulus(4'b1000, 4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_rdy", rdy4, 0);
      tick();
      checkOutput("bp_vld", ov4, 1);
      checkOutput("bp_bin", ob4, 2);
      checkOutput("bp_dat", od4, 8'hA2);
    end
    outRdy4 = 1'b1;
    #1;
    checkOutput("bp_release_rdy", rdy4, 4'b1000);
    tick();
    checkOutput("bp_drain_bin", ob4, 3);
    checkOutput("bp_drain_dat", od4, 8'hC3);
    checkOutput("bp_drain_vld", ov4, 1);

    // Reset while locked on req 2
    dat4[2] = 8'hD2;
    applyStimulus(4'b0100, 4'b1011, 1'b1);
    checkOutput("mid_rdy", rdy4, 4'b0100);
    tick();
    checkOutput("mid_bin", ob4, 2);
    checkOutput("mid_lst", ol4, 0);
    vld4[0] = 1'b1;
    #1;
    checkOutput("mid_lock_rdy", rdy4, 4'b0100);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_vld", ov4, 0);
    checkOutput("mid_rst_bin", ob4, 0);
    checkOutput("mid_rst_rdy", rdy4, 0);
    tick();
    rstN = 1'b1;
    #1;
    checkOutput("post_rst_rdy", rdy4, 4'b0001);
    tick();
    checkOutput("post_rst_bin", ob4, 0);
    checkOutput("post_rst_dat", od4, 8'hA0);
    vld4[0] = 1'b0;
    #1;
    checkOutput("post_rst_rdy2", rdy4, 4'b0100);
    tick();
    checkOutput("post_rst_bin2", ob4, 2);
    vld4 = '0;

    // WIDTH=5 wrap from index 4 back to 0
    vld5 = 5'b10000;
    #1;
    checkOutput("w5_rdy0", rdy5, 5'b10000);
    tick();
    checkOutput("w5_bin0", ob5, 4);
    checkOutput("w5_dat0", od5, 8'h54);
    vld5 = 5'b00001;
    #1;
    checkOutput("w5_rdy1", rdy5, 5'b00001);
    tick();
    checkOutput("w5_bin1", ob5, 0);
    checkOutput("w5_dat1", od5, 8'h50);
    vld5 = 5'b10001;
    #1;
    checkOutput("w5_rdy2", rdy5, 5'b10000);
    tick();
    checkOutput("w5_bin2", ob5, 4);
    vld5 = 5'b00001;
    #1;
    checkOutput("w5_rdy3", rdy5, 5'b00001);
    tick();
    checkOutput("w5_bin3", ob5, 0);
    checkOutput("w5_vld3", ov5, 1);
    vld5 = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
